// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out frame transmitter with optional even parity
// Ports:
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset
//   din   in  WIDTH  parallel word, sampled only on an accepted load
//   load  in  1      request to accept din
//   ready out 1      a load will be accepted on the next edge
//   tx    out 1      serial line, idles high
//   busy  out 1      a frame is on the line
//   done  out 1      one-cycle pulse in the final stop-bit cycle
module piso_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [IW-1:0]    idx, idx_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic             par, par_d;
    logic             tx_d, ready_d, busy_d, done_d;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    // State register. Outputs are registered from the next-state decode so
    // they line up with the state they describe, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
            par   <= par_d;
            tx    <= tx_d;
            ready <= ready_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        idx_d   = idx;
        shreg_d = shreg;
        par_d   = par;
        cnt_d   = (state == S_IDLE || bit_end) ? '0 : cnt + 1'b1;
        case (state)
            S_IDLE: begin
                if (load && ready) begin
                    state_d = S_START;
                    idx_d   = '0;
                    shreg_d = din;
                    par_d   = ^din;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // Shift so the next bit to send always sits in shreg[0]
                    shreg_d = shreg >> 1;
                    if (idx == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state, captured by the state register
    always_comb begin
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized self-checking bench for piso_tx in three configurations
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_r [3];
    logic [2:0] load_r;
    logic [2:0] ready_w, tx_w, busy_w, done_w;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut0 (
        .clk(clk), .rst(rst), .din(din_r[0]), .load(load_r[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut1 (
        .clk(clk), .rst(rst), .din(din_r[1]), .load(load_r[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
    piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .clk(clk), .rst(rst), .din(din_r[2]), .load(load_r[2]),
        .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    // Reference model: a frame is a list of slots (start, 8 data LSB first,
    // optional parity, stop), each lasting cpb cycles.
    function automatic int cpb(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int par_en(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    function automatic int frame_len(input int d);
        return (2 + 8 + par_en(d)) * cpb(d);
    endfunction

    function automatic logic exp_tx(input int d, input logic [7:0] data, input int k);
        int slot;
        slot = k / cpb(d);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return data[slot-1];
        if (slot == 9 && par_en(d) == 1) return ^data;
        return 1'b1;
    endfunction

    // {tx, busy, ready, done}
    task automatic test_reset();
        logic [3:0] got;
        rst    = 1'b1;
        load_r = 3'b000;
        for (int d = 0; d < 3; d++) din_r[d] = 8'($urandom);
        repeat (2) @(negedge clk);
        load_r = 3'b111;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            got = {tx_w[d], busy_w[d], ready_w[d], done_w[d]};
            checks++;
            if (got !== 4'b1010) $display("FAIL reset_with_load dut%0d: got %b expected 1010", d, got);
            else passes++;
        end
        rst    = 1'b0;
        load_r = 3'b000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                got = {tx_w[d], busy_w[d], ready_w[d], done_w[d]};
                checks++;
                if (got !== 4'b1010) $display("FAIL idle_after_reset dut%0d cycle %0d: got %b expected 1010", d, c, got);
                else passes++;
            end
        end
    endtask

    // One frame; din is scrambled after acceptance, and an optional stray
    // load is pulsed at frame cycle ignore_at+1.
    task automatic test_frame(input int d, input logic [7:0] data, input int ignore_at, input string name);
        int         len;
        logic [3:0] got, want;
        len = frame_len(d);
        @(negedge clk);
        din_r[d]  = data;
        load_r[d] = 1'b1;
        @(negedge clk);
        load_r[d] = 1'b0;
        for (int k = 0; k < len; k++) begin
            want = {exp_tx(d, data, k), 1'b1, 1'b0, (k == len - 1)};
            got  = {tx_w[d], busy_w[d], ready_w[d], done_w[d]};
            checks++;
            if (got !== want) $display("FAIL %s dut%0d din=%h cycle %0d: got %b expected %b", name, d, data, k + 1, got, want);
            else passes++;
            din_r[d]  = (k == ignore_at) ? 8'hFF : 8'($urandom);
            load_r[d] = (k == ignore_at);
            @(negedge clk);
        end
        load_r[d] = 1'b0;
        got = {tx_w[d], busy_w[d], ready_w[d], done_w[d]};
        checks++;
        if (got !== 4'b1010) $display("FAIL %s_idle dut%0d: got %b expected 1010", name, d, got);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int         len;
        logic [7:0] words [2];
        logic [3:0] got, want;
        len      = frame_len(0);
        words[0] = 8'h3C;
        words[1] = 8'hC3;
        @(negedge clk);
        din_r[0]  = words[0];
        load_r[0] = 1'b1;
        @(negedge clk);
        din_r[0] = words[1];
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                load_r[0] = 1'b0;
                din_r[0]  = 8'($urandom);
            end
            for (int k = 0; k < len; k++) begin
                want = {exp_tx(0, words[f], k), 1'b1, 1'b0, (k == len - 1)};
                got  = {tx_w[0], busy_w[0], ready_w[0], done_w[0]};
                checks++;
                if (got !== want) $display("FAIL back_to_back frame %0d cycle %0d: got %b expected %b", f, k + 1, got, want);
                else passes++;
                @(negedge clk);
            end
            got = {tx_w[0], busy_w[0], ready_w[0], done_w[0]};
            checks++;
            if (got !== 4'b1010) $display("FAIL back_to_back gap %0d: got %b expected 1010", f, got);
            else passes++;
            if (f == 0) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         len;
        logic [7:0] data;
        logic [3:0] got, want;
        len  = frame_len(0);
        data = 8'($urandom);
        @(negedge clk);
        din_r[0]  = data;
        load_r[0] = 1'b1;
        @(negedge clk);
        load_r[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            want = {exp_tx(0, data, k), 1'b1, 1'b0, 1'b0};
            got  = {tx_w[0], busy_w[0], ready_w[0], done_w[0]};
            checks++;
            if (got !== want) $display("FAIL abort_prefix cycle %0d: got %b expected %b", k + 1, got, want);
            else passes++;
            if (k == 19) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        for (int c = 0; c < len + 4; c++) begin
            got = {tx_w[0], busy_w[0], ready_w[0], done_w[0]};
            checks++;
            if (got !== 4'b1010) $display("FAIL abort_idle cycle %0d after reset: got %b expected 1010", c, got);
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        load_r = 3'b000;
        for (int d = 0; d < 3; d++) din_r[d] = 8'h00;
        rst = 1'b1;
        test_reset();
        test_frame(0, 8'hA5, -1, "frame_a5");
        test_frame(1, 8'h07, -1, "parity_07");
        test_frame(2, 8'h01, -1, "fast_01");
        test_frame(0, 8'h00, 9, "ignore_load");
        test_back_to_back();
        test_reset_mid_frame();
        test_frame(0, 8'h5A, -1, "after_abort_5a");
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(0, 1) == 1)
                    test_frame(d, 8'($urandom), -1, "random");
                else
                    test_frame(d, 8'($urandom), int'($urandom_range(0, frame_len(d) - 2)), "random_stray_load");
            end
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
